lfsr_keysearch_decrypt: RTL and testbench
=========================================

Name: lfsr_keysearch_decrypt

Overview:
Parametrised successor to the Lab 5b decryptor. Recovers an unknown LFSR tap pattern and start state from a pad-preambled ciphertext in data memory, decrypts it, strips the leading pad run and writes plaintext back to memory. It sits between the sequencer and the data-memory core, and drives that core through one synchronous read port and one write port. LFSR width, byte width, message length, memory bases and the tap-pattern set are generic.

Parameters:
DW, 8, data byte width
LW, 6, LFSR width (LW ≤ DW); keystream is the state zero-extended to DW
AW, 8, memory address width
MSG_LEN, 64, ciphertext/plaintext length in bytes
CT_BASE, 128, ciphertext base address
PT_BASE, 192, plaintext base address
PRE_MIN, 7, guaranteed minimum preamble length (≥ LW+1)
PAD, 8'h7E, preamble/trailer pad character
NUM_PTRN, 6, number of candidate tap patterns (taken from package table)

Ports:
clk  in  1  clock
init_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when IDLE
rd_addr  out  AW  memory read address
rd_data  in  DW  read data, valid the cycle after rd_addr
wr_en  out  1  memory write strobe
wr_addr  out  AW  memory write address
wr_data  out  DW  memory write data
busy  out  1  high from start accepted until done
done  out  1  sticky; high in DONE until next start or reset
match  out  1  a tap pattern was found
ptrn_idx  out  $clog2(NUM_PTRN)  index of the found pattern
key_init  out  LW  recovered start state
lead_cnt  out  AW  number of stripped leading pad bytes

Behaviour:
- Reset (init_n low, any state, mid-run included): state goes to IDLE. All outputs go to 0. The key buffer is cleared. Pending writes are dropped.
- Keystream: s[i+1] = {s[i][LW-2:0], ^(s[i] & taps)}. ct[i] = pt[i] ^ {0, s[i]}.
- IDLE: ignores start while busy. start in IDLE goes to LOAD. start in any other state is ignored.
- LOAD: reads CT_BASE..CT_BASE+PRE_MIN-1 back-to-back over PRE_MIN+1 cycles. Stores k[j] = rd_data[LW-1:0] ^ PAD[LW-1:0]. Any upper bits that disagree with PAD mean no preamble: the run ends in DONE with match=0.
- SEARCH: one cycle per candidate, starting at index 0. A candidate hits when next(k[j]) == k[j+1] for all j < PRE_MIN-1; all comparisons run in parallel. The first hit latches ptrn_idx, sets key_init = k[0] and match=1, then goes to DECRYPT. If no candidate hits after NUM_PTRN cycles, go to DONE with match=0 and no writes.
- DECRYPT: pipelined at one byte per cycle. Read at cycle t, XOR at cycle t+1, write at cycle t+1.
- Leading-pad stripping: while the stripping flag is set, decrypted bytes equal to PAD are not written and each one increments lead_cnt. The first non-PAD byte clears the flag, and every later byte (including PAD) is written to PT_BASE + (i - lead_cnt).
- The last ciphertext address is CT_BASE+MSG_LEN-1; after it the block goes to FILL.
- FILL: writes PAD to the remaining lead_cnt plaintext addresses, so exactly MSG_LEN writes land in PT region. If every byte decrypts to PAD: lead_cnt=MSG_LEN and FILL writes MSG_LEN PADs.
- DONE: done=1, busy=0. Stays in DONE; start goes to LOAD and clears done, match and lead_cnt in the same cycle.
- Address arithmetic is AW bits. Base+offset must not wrap; this is an elaboration-time assert.
- wr_en is never high in IDLE, LOAD, SEARCH or DONE.

Decomposition:
- Package lfsr_pkg holds:
  - state_t enum {IDLE, LOAD, SEARCH, DECRYPT, FILL, DONE}
  - TAP_TABLE[6] = {6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39}
  - PAD_CHAR = 8'h7E
  - function lfsr_next(state, taps)
- Sub-module lfsr_step: combinational next-state generator, parametrised by LW. It is instantiated PRE_MIN-1 times for SEARCH and once for the DECRYPT keystream register.

Test Plan:
- Pattern 2 (6'h30), key 6'h01, preamble 7, "Hey_Hamm_Look_Im_Picasso" -> match=1, ptrn_idx=2, key_init=6'h01, lead_cnt=7. mem[192..215] equals the string, mem[216..255]=8'h7E, done within MSG_LEN+PRE_MIN+NUM_PTRN+8 cycles.
- Pattern 5, key 6'h3F, preamble 12, message starting "~~x" -> lead_cnt=14. mem[192]="x", 14 trailing PADs.
- Ciphertext byte 0 with bit7 set (no valid preamble) -> done=1, match=0, zero writes.
- Ciphertext encrypted with tap 6'h1F (not in table) -> after 6 SEARCH cycles done=1, match=0, wr_en never asserted.
- init_n pulsed low mid-DECRYPT (byte 30) -> outputs 0 immediately. A fresh start then produces a correct full decrypt.
- start during busy and a second start in DONE -> the first is ignored. The second reruns with done dropping for ≥1 cycle and identical results.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR key-search decryptor.
// Holds the FSM state encoding, candidate tap table, pad character
// and a reference LFSR step function for the 6-bit register.
package lfsr_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECRYPT, FILL, DONE} state_t;

  localparam int TAP_W    = 6;
  localparam int NUM_TAPS = 6;

  localparam logic [TAP_W-1:0] TAP_TABLE [NUM_TAPS] =
    '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] PAD_CHAR = 8'h7E;

  // Shift left, feedback bit is the parity of the tapped state bits.
  function automatic logic [TAP_W-1:0] lfsr_next(input logic [TAP_W-1:0] state,
                                                 input logic [TAP_W-1:0] taps);
    return {state[TAP_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Purpose: combinational LFSR next-state generator.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int LW = 6
) (
  input  logic [LW-1:0] state,
  input  logic [LW-1:0] taps,
  output logic [LW-1:0] nxt
);

  if (LW == TAP_W) begin : g_pkg
    assign nxt = lfsr_next(state, taps);
  end else begin : g_generic
    assign nxt = {state[LW-2:0], ^(state & taps)};
  end

endmodule

// File: rtl/lfsr_keysearch_decrypt.sv
// Purpose: recover LFSR taps/seed from a pad preamble, decrypt, strip leading pads.
// Latency: PRE_MIN+1 load, <=NUM_PTRN search, MSG_LEN+1 decrypt, lead_cnt+1 fill cycles.
// Backpressure: none; memory is assumed to accept one read and one write per cycle.
module lfsr_keysearch_decrypt
  import lfsr_pkg::*;
#(
  parameter int             DW       = 8,
  parameter int             LW       = 6,
  parameter int             AW       = 8,
  parameter int             MSG_LEN  = 64,
  parameter int             CT_BASE  = 128,
  parameter int             PT_BASE  = 192,
  parameter int             PRE_MIN  = 7,
  parameter logic [DW-1:0]  PAD      = DW'(PAD_CHAR),
  parameter int             NUM_PTRN = 6
) (
  input  logic                        clk,
  input  logic                        init_n,
  input  logic                        start,
  output logic [AW-1:0]               rd_addr,
  input  logic [DW-1:0]               rd_data,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_addr,
  output logic [DW-1:0]               wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        match,
  output logic [$clog2(NUM_PTRN)-1:0] ptrn_idx,
  output logic [LW-1:0]               key_init,
  output logic [AW-1:0]               lead_cnt
);

  localparam int IW = $clog2(NUM_PTRN);
  localparam int CW = $clog2(MSG_LEN + 1);

  // Parameter sanity: regions must not wrap and the table must cover the candidates.
  if (CT_BASE + MSG_LEN > (1 << AW)) begin : g_ct_wrap
    $error("ciphertext region wraps the address space");
  end
  if (PT_BASE + MSG_LEN > (1 << AW)) begin : g_pt_wrap
    $error("plaintext region wraps the address space");
  end
  if (NUM_PTRN > NUM_TAPS || LW > DW || PRE_MIN < LW + 1 || PRE_MIN > MSG_LEN) begin : g_cfg
    $error("inconsistent key-search parameters");
  end

  state_t          state;
  logic [LW-1:0]   key_buf [PRE_MIN];
  logic [LW-1:0]   key_nxt [PRE_MIN-1];
  logic [PRE_MIN-2:0] link_ok;
  logic            cand_hit;
  logic [IW-1:0]   cand;
  logic [LW-1:0]   cand_taps;
  logic [LW-1:0]   taps_q;
  logic [LW-1:0]   ks;
  logic [LW-1:0]   ks_nxt;
  logic [CW-1:0]   rd_cnt;
  logic [CW-1:0]   wr_off;
  logic            rd_on;
  logic            dat_vld;
  logic            dat_last;
  logic            strip;
  logic            pre_bad;
  logic [DW-1:0]   pt_byte;

  // Select the tap pattern for the candidate currently under test.
  always_comb begin
    cand_taps = '0;
    for (int p = 0; p < NUM_PTRN; p++) begin
      if (cand == IW'(p)) cand_taps = LW'(TAP_TABLE[p]);
    end
  end

  // Every consecutive key pair is checked against the candidate in parallel.
  for (genvar j = 0; j < PRE_MIN - 1; j++) begin : g_link
    lfsr_step #(.LW(LW)) u_step (
      .state (key_buf[j]),
      .taps  (cand_taps),
      .nxt   (key_nxt[j])
    );
    assign link_ok[j] = (key_nxt[j] == key_buf[j+1]);
  end
  assign cand_hit = &link_ok;

  lfsr_step #(.LW(LW)) u_ks (
    .state (ks),
    .taps  (taps_q),
    .nxt   (ks_nxt)
  );

  // Bits above the LFSR width carry no keystream, so they must equal the pad.
  assign pre_bad = (((rd_data ^ PAD) >> LW) != '0);
  assign pt_byte = rd_data ^ DW'(ks);

  // Control FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      ptrn_idx <= '0;
      key_init <= '0;
      lead_cnt <= '0;
      cand     <= '0;
      taps_q   <= '0;
      ks       <= '0;
      rd_cnt   <= '0;
      wr_off   <= '0;
      rd_on    <= 1'b0;
      dat_vld  <= 1'b0;
      dat_last <= 1'b0;
      strip    <= 1'b0;
      for (int j = 0; j < PRE_MIN; j++) key_buf[j] <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            done     <= 1'b0;
            match    <= 1'b0;
            lead_cnt <= '0;
            rd_addr  <= AW'(CT_BASE);
            rd_cnt   <= '0;
          end
        end
        LOAD: begin
          rd_cnt <= rd_cnt + CW'(1);
          if (rd_cnt < CW'(PRE_MIN - 1)) rd_addr <= rd_addr + AW'(1);
          for (int j = 0; j < PRE_MIN; j++) begin
            if (rd_cnt == CW'(j + 1)) key_buf[j] <= rd_data[LW-1:0] ^ PAD[LW-1:0];
          end
          if (rd_cnt == CW'(PRE_MIN)) begin
            state <= SEARCH;
            cand  <= '0;
          end
          if (rd_cnt != '0 && pre_bad) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        SEARCH: begin
          if (cand_hit) begin
            state    <= DECRYPT;
            match    <= 1'b1;
            ptrn_idx <= cand;
            key_init <= key_buf[0];
            taps_q   <= cand_taps;
            ks       <= key_buf[0];
            rd_addr  <= AW'(CT_BASE);
            rd_cnt   <= '0;
            rd_on    <= 1'b1;
            dat_vld  <= 1'b0;
            dat_last <= 1'b0;
            strip    <= 1'b1;
            wr_off   <= '0;
          end else if (cand == IW'(NUM_PTRN - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cand <= cand + IW'(1);
          end
        end
        DECRYPT: begin
          dat_vld  <= rd_on;
          dat_last <= rd_on && (rd_cnt == CW'(MSG_LEN - 1));
          if (rd_on) begin
            if (rd_cnt == CW'(MSG_LEN - 1)) begin
              rd_on <= 1'b0;
            end else begin
              rd_cnt  <= rd_cnt + CW'(1);
              rd_addr <= rd_addr + AW'(1);
            end
          end
          if (dat_vld) begin
            ks <= ks_nxt;
            if (strip && pt_byte == PAD) begin
              lead_cnt <= lead_cnt + AW'(1);
            end else begin
              strip   <= 1'b0;
              wr_en   <= 1'b1;
              wr_addr <= AW'(PT_BASE) + AW'(wr_off);
              wr_data <= pt_byte;
              wr_off  <= wr_off + CW'(1);
            end
            if (dat_last) state <= FILL;
          end
        end
        FILL: begin
          if (wr_off == CW'(MSG_LEN)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= AW'(PT_BASE) + AW'(wr_off);
            wr_data <= PAD;
            wr_off  <= wr_off + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_keysearch_decrypt.sv
// Purpose: directed self-checking bench for the LFSR key-search decryptor.
// Latency: checks completion budgets and exact search-fail timing.
// Backpressure: behavioural memory with one-cycle synchronous read.
module tb_lfsr_keysearch_decrypt;

  localparam int         MSG_LEN = 64;
  localparam int         CT_BASE = 128;
  localparam int         PT_BASE = 192;
  localparam logic [7:0] PAD     = 8'h7E;

  logic       clk;
  logic       init_n;
  logic       start;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       match;
  logic [2:0] ptrn_idx;
  logic [5:0] key_init;
  logic [7:0] lead_cnt;

  lfsr_keysearch_decrypt dut (
    .clk      (clk),
    .init_n   (init_n),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .ptrn_idx (ptrn_idx),
    .key_init (key_init),
    .lead_cnt (lead_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: synchronous read, write port, and a loader used by the bench.
  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  int         wr_cnt = 0;
  int         oob_cnt = 0;
  int         bad_wr = 0;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (ld_en) mem[ld_addr] <= ld_data;
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_cnt <= wr_cnt + 1;
      if (wr_addr < 8'(PT_BASE)) oob_cnt <= oob_cnt + 1;
    end
  end

  // A write strobe outside a busy run is always an error.
  always @(negedge clk) begin
    if (wr_en && !busy) bad_wr <= bad_wr + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [7:0] pt [MSG_LEN];
  logic [7:0] ct [MSG_LEN];

  task automatic build(input logic [5:0] taps, input logic [5:0] key, input int pre,
                       input string msg, input bit badbit);
    logic [5:0] s;
    s = key;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (i < pre) pt[i] = PAD;
      else if (i - pre < msg.len()) pt[i] = msg[i-pre];
      else pt[i] = PAD;
      ct[i] = pt[i] ^ {2'b00, s};
      s = {s[4:0], ^(s & taps)};
    end
    if (badbit) ct[0] = ct[0] | 8'h80;
  endtask

  task automatic load_all();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_data = (a >= CT_BASE && a < CT_BASE + MSG_LEN) ? ct[a-CT_BASE] : 8'h00;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_pt();
    for (int a = PT_BASE; a < PT_BASE + MSG_LEN; a++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_data = 8'h00;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Expected plaintext image: leading pads removed, tail refilled with pads.
  function automatic int img_mism();
    int lead;
    int bad;
    logic [7:0] e;
    lead = 0;
    while (lead < MSG_LEN && pt[lead] == PAD) lead++;
    bad = 0;
    for (int j = 0; j < MSG_LEN; j++) begin
      e = (j < MSG_LEN - lead) ? pt[j+lead] : PAD;
      if (mem[PT_BASE+j] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int pt_nonzero();
    int n;
    n = 0;
    for (int j = 0; j < MSG_LEN; j++) if (mem[PT_BASE+j] !== 8'h00) n++;
    return n;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while (!done && cyc < bound) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  typedef struct {
    logic [5:0] taps;
    logic [5:0] key;
    int         pre;
    int         msg_sel;
    bit         badbit;
    bit         exp_match;
    int         exp_idx;
    logic [5:0] exp_key;
    int         exp_lead;
    int         exp_wr;
    int         max_cyc;
    int         exact_cyc;
  } vec_t;

  vec_t  vecs [4];
  string msgs [2];

  initial begin
    int cyc;
    int base;

    msgs[0] = "Hey_Hamm_Look_Im_Picasso";
    msgs[1] = "~~xylophone_tune";
    vecs[0] = '{taps:6'h30, key:6'h01, pre:7,  msg_sel:0, badbit:1'b0, exp_match:1'b1,
                exp_idx:2, exp_key:6'h01, exp_lead:7,  exp_wr:64, max_cyc:85,  exact_cyc:-1};
    vecs[1] = '{taps:6'h39, key:6'h3F, pre:12, msg_sel:1, badbit:1'b0, exp_match:1'b1,
                exp_idx:5, exp_key:6'h3F, exp_lead:14, exp_wr:64, max_cyc:200, exact_cyc:-1};
    vecs[2] = '{taps:6'h30, key:6'h01, pre:7,  msg_sel:0, badbit:1'b1, exp_match:1'b0,
                exp_idx:0, exp_key:6'h00, exp_lead:0,  exp_wr:0,  max_cyc:200, exact_cyc:-1};
    vecs[3] = '{taps:6'h1F, key:6'h2A, pre:7,  msg_sel:0, badbit:1'b0, exp_match:1'b0,
                exp_idx:0, exp_key:6'h00, exp_lead:0,  exp_wr:0,  max_cyc:200, exact_cyc:14};

    // Reset state
    init_n = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_lead", lead_cnt, 0);
    chk("rst_ptrn_idx", ptrn_idx, 0);
    chk("rst_key_init", key_init, 0);
    @(negedge clk);
    init_n = 1'b1;

    // Table-driven runs
    for (int v = 0; v < 4; v++) begin
      build(vecs[v].taps, vecs[v].key, vecs[v].pre, msgs[vecs[v].msg_sel], vecs[v].badbit);
      load_all();
      base = wr_cnt;
      pulse_start();
      chk($sformatf("v%0d_busy_start", v), busy, 1);
      wait_done(vecs[v].max_cyc, cyc);
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_match", v), match, vecs[v].exp_match);
      chk($sformatf("v%0d_lead", v), lead_cnt, vecs[v].exp_lead);
      chk($sformatf("v%0d_writes", v), wr_cnt - base, vecs[v].exp_wr);
      if (vecs[v].exp_match) begin
        chk($sformatf("v%0d_ptrn_idx", v), ptrn_idx, vecs[v].exp_idx);
        chk($sformatf("v%0d_key_init", v), key_init, vecs[v].exp_key);
        chk($sformatf("v%0d_image_mism", v), img_mism(), 0);
      end else begin
        chk($sformatf("v%0d_pt_untouched", v), pt_nonzero(), 0);
      end
      if (vecs[v].exact_cyc >= 0) chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exact_cyc);
      if (vecs[v].msg_sel == 1) begin
        chk($sformatf("v%0d_first_byte", v), mem[PT_BASE], 8'h78);
        chk($sformatf("v%0d_last_pad", v), mem[PT_BASE+MSG_LEN-14], PAD);
      end
    end

    // Reset pulse in the middle of a decrypt, then a clean rerun
    build(6'h30, 6'h01, 7, msgs[0], 1'b0);
    load_all();
    pulse_start();
    cyc = 0;
    while (!(busy && rd_addr == 8'(CT_BASE + 30)) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_reached_byte30", rd_addr, CT_BASE + 30);
    #2;
    init_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {busy, done, match, wr_en, rd_addr, wr_addr, wr_data,
                            lead_cnt, ptrn_idx, key_init}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_n = 1'b1;
    clear_pt();
    base = wr_cnt;
    pulse_start();
    wait_done(200, cyc);
    chk("rerun_done", done, 1);
    chk("rerun_match", match, 1);
    chk("rerun_ptrn_idx", ptrn_idx, 2);
    chk("rerun_key_init", key_init, 6'h01);
    chk("rerun_lead", lead_cnt, 7);
    chk("rerun_writes", wr_cnt - base, MSG_LEN);
    chk("rerun_image_mism", img_mism(), 0);

    // Start while busy is ignored; start in DONE reruns
    build(6'h39, 6'h3F, 12, msgs[1], 1'b0);
    load_all();
    base = wr_cnt;
    pulse_start();
    repeat (40) @(posedge clk);
    pulse_start();
    chk("busy_start_ignored_busy", busy, 1);
    chk("busy_start_ignored_done", done, 0);
    wait_done(200, cyc);
    chk("busy_run_done", done, 1);
    chk("busy_run_lead", lead_cnt, 14);
    chk("busy_run_writes", wr_cnt - base, MSG_LEN);
    chk("busy_run_image_mism", img_mism(), 0);
    clear_pt();
    chk("done_sticky", done, 1);
    base = wr_cnt;
    pulse_start();
    chk("restart_done_drop", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_match_clr", match, 0);
    chk("restart_lead_clr", lead_cnt, 0);
    wait_done(200, cyc);
    chk("restart_done", done, 1);
    chk("restart_match", match, 1);
    chk("restart_ptrn_idx", ptrn_idx, 5);
    chk("restart_key_init", key_init, 6'h3F);
    chk("restart_lead", lead_cnt, 14);
    chk("restart_writes", wr_cnt - base, MSG_LEN);
    chk("restart_image_mism", img_mism(), 0);
    chk("restart_first_byte", mem[PT_BASE], 8'h78);

    // Global write-port hygiene
    @(negedge clk);
    chk("wr_en_while_idle", bad_wr, 0);
    chk("writes_outside_pt", oob_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
